tt_bist_harness: RTL and testbench

Parametrised built-in self-test harness for a TinyTapeout user design. It holds the design under test (DUT) in reset, then drives a pseudo-random stimulus stream onto the DUT's dedicated inputs. It compacts the DUT's dedicated outputs into a 16-bit MISR signature, optionally comparing it against a golden value. It sits between the chip-level pins and the wrapped `tt_um_*` core, so any user project can be checked on silicon without an external pattern generator.

---
 rtl/tt_bist_harness.sv | 191 +++++++++++++++++++
 tb/tb_tt_bist_harness.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_bist_harness.sv
// tt_bist_harness: BIST wrapper for a TinyTapeout user core.
// The core is held in reset and then fed a Galois LFSR stimulus stream.
// Its responses are compacted into a 16-bit MISR signature.
// Optional feature macro: BIST_COMPARE_EN adds a registered golden-signature
// comparator that drives `pass`.
module tt_bist_harness #(
    parameter int unsigned  IN_W        = 8,
    parameter int unsigned  OUT_W       = 8,
    parameter int unsigned  NUM_VECTORS = 256,
    parameter int unsigned  LATENCY     = 1,
    parameter int unsigned  RST_CYC     = 4,
    parameter logic [15:0]  SEED        = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             dut_rst_n,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic [15:0]      signature,
    input  logic [15:0]      golden,
    output logic             pass
);

    localparam logic [15:0] POLY   = 16'hB400;
    localparam int unsigned VC_W   = $clog2(NUM_VECTORS + 1);
    localparam int unsigned PH_MAX = (RST_CYC > LATENCY) ? RST_CYC : LATENCY;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    localparam logic [VC_W-1:0] VEC_LAST   = VC_W'(NUM_VECTORS);
    localparam logic [PH_W-1:0] RST_LAST   = PH_W'(RST_CYC - 1);
    localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUT_RST,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [15:0]     lfsr;
    logic [15:0]     misr;
    logic [15:0]     misr_next;
    logic [VC_W-1:0] vec_cnt;
    logic [PH_W-1:0] ph_cnt;
    logic            drv_v;
    logic            cap;
    logic            start_acc;

    assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));
    assign signature = misr;

    // MISR next value, folding in the response when the delayed valid fires
    always_comb begin
        misr_next = misr;
        if (cap) begin
            misr_next = (misr >> 1) ^ (misr[0] ? POLY : 16'h0000) ^ 16'(dut_out);
        end
    end

    // Valid delay line aligning "vector driven" with its response
    generate
        if (LATENCY == 0) begin : g_nodly
            assign cap = drv_v;
        end else begin : g_dly
            logic [LATENCY-1:0] dly;
            // Shift the driven flag LATENCY cycles
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dly <= '0;
                end else begin
                    dly[0] <= drv_v;
                    for (int unsigned i = 1; i < LATENCY; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end
            assign cap = dly[LATENCY-1];
        end
    endgenerate

    // Signature register: cleared on an accepted start, updated on capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misr <= '0;
        end else if (start_acc) begin
            misr <= '0;
        end else begin
            misr <= misr_next;
        end
    end

    // Run sequencer with registered control outputs and stimulus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            dut_rst_n <= 1'b0;
            dut_in    <= '0;
            lfsr      <= SEED;
            vec_cnt   <= '0;
            ph_cnt    <= '0;
            drv_v     <= 1'b0;
`ifdef BIST_COMPARE_EN
            pass      <= 1'b0;
`endif
        end else begin
            drv_v <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    dut_rst_n <= 1'b1;
                    if (start) begin
                        state     <= S_DUT_RST;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        dut_rst_n <= 1'b0;
                        lfsr      <= SEED;
                        vec_cnt   <= '0;
                        ph_cnt    <= '0;
`ifdef BIST_COMPARE_EN
                        pass      <= 1'b0;
`endif
                    end
                end
                S_DUT_RST: begin
                    if (ph_cnt == RST_LAST) begin
                        // The edge leaving reset already drives vector 1
                        state     <= S_RUN;
                        dut_rst_n <= 1'b1;
                        ph_cnt    <= '0;
                        dut_in    <= lfsr[IN_W-1:0];
                        lfsr      <= (lfsr >> 1) ^ (lfsr[0] ? POLY : 16'h0000);
                        vec_cnt   <= VC_W'(1);
                        drv_v     <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (vec_cnt == VEC_LAST) begin
                        if (LATENCY == 0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef BIST_COMPARE_EN
                            pass  <= (misr_next == golden);
`endif
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        dut_in  <= lfsr[IN_W-1:0];
                        lfsr    <= (lfsr >> 1) ^ (lfsr[0] ? POLY : 16'h0000);
                        vec_cnt <= vec_cnt + 1'b1;
                        drv_v   <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (ph_cnt == DRAIN_LAST) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        ph_cnt <= '0;
`ifdef BIST_COMPARE_EN
                        pass   <= (misr_next == golden);
`endif
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifndef BIST_COMPARE_EN
    logic unused_golden;
    assign unused_golden = ^golden;
    assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_tt_bist_harness.sv
// Directed bench for tt_bist_harness: default instance with a registered
// stand-in core (response = stimulus ^ 8'h5A) and a single-vector instance.
module tb_tt_bist_harness;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, dut_rst_n, pass;
    logic [7:0]  dut_in;
    logic [7:0]  dut_out;
    logic [15:0] signature;
    logic [15:0] golden = 16'h0000;

    logic        start1 = 1'b0;
    logic        busy1, done1, dut_rst_n1, pass1;
    logic [7:0]  dut_in1;
    logic [15:0] signature1;
    logic [15:0] golden1 = 16'h0001;

    logic        zero_mode = 1'b1;
    logic [7:0]  resp;

    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    tt_bist_harness u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .dut_rst_n (dut_rst_n),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .signature (signature),
        .golden    (golden),
        .pass      (pass)
    );

    tt_bist_harness #(
        .NUM_VECTORS (1),
        .LATENCY     (0)
    ) u_one (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .busy      (busy1),
        .done      (done1),
        .dut_rst_n (dut_rst_n1),
        .dut_in    (dut_in1),
        .dut_out   (8'h01),
        .signature (signature1),
        .golden    (golden1),
        .pass      (pass1)
    );

    // Stand-in core with one cycle of latency
    always_ff @(posedge clk) begin
        if (!dut_rst_n) resp <= 8'h00;
        else            resp <= dut_in ^ 8'h5A;
    end
    assign dut_out = zero_mode ? 8'h00 : resp;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept a start on the next edge (edge E); returns #1 after E
    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Step until done, counting edges after E; optional mid-run start pulse
    task automatic wait_done(input int pulse_at, output int cyc);
        cyc = 0;
        while (!done && cyc < 400) begin
            start = (cyc == pulse_at);
            step();
            cyc++;
        end
        start = 1'b0;
    endtask

    function automatic logic [15:0] model_sig();
        logic [15:0] l;
        logic [15:0] m;
        logic [7:0]  r;
        l = 16'hACE1;
        m = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            r = l[7:0] ^ 8'h5A;
            m = (m >> 1) ^ (m[0] ? 16'hB400 : 16'h0000) ^ {8'h00, r};
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end
        return m;
    endfunction

    initial begin
        int          cyc;
        logic [15:0] model;
        logic [15:0] sig_a;
        logic        exp_pass;

        model = model_sig();

        // Reset values
        step();
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dut_rst_n", dut_rst_n, 1'b0);
        check("rst_dut_in", dut_in, 8'h00);
        check("rst_signature", signature, 16'h0000);
        check("rst_pass", pass, 1'b0);
        rst = 1'b0;
        step();
        check("idle_dut_rst_n", dut_rst_n, 1'b1);
        check("idle_busy", busy, 1'b0);

        // Run 1: zero response, timing and stimulus sequence
        zero_mode = 1'b1;
        launch();
        check("e_busy", busy, 1'b1);
        check("e_dut_rst_n", dut_rst_n, 1'b0);
        for (int k = 1; k < 4; k++) begin
            step();
            check("rstlow_dut_rst_n", dut_rst_n, 1'b0);
        end
        step();
        check("run1_dut_rst_n", dut_rst_n, 1'b1);
        check("vec1", dut_in, 8'hE1);
        step();
        check("vec2", dut_in, 8'h70);
        step();
        check("vec3", dut_in, 8'h38);
        wait_done(-1, cyc);
        cyc += 6;
        check("zero_done_cycle", cyc, 261);
        check("zero_busy", busy, 1'b0);
        check("zero_signature", signature, 16'h0000);

        // Run 2: live response, restart from DONE, ignored start mid-RUN
        zero_mode = 1'b0;
        launch();
        check("restart_done_low", done, 1'b0);
        check("restart_busy", busy, 1'b1);
        wait_done(100, cyc);
        check("run2_done_cycle", cyc, 261);
        check("run2_signature", signature, model);
        sig_a = signature;
        step();
        step();
        check("done_hold", done, 1'b1);
        check("sig_stable", signature, sig_a);

        // Run 3: identical DUT gives identical signature
        launch();
        wait_done(-1, cyc);
        check("run3_done_cycle", cyc, 261);
        check("run3_signature", signature, sig_a);

        // Reset mid-run
        launch();
        for (int k = 0; k < 50; k++) step();
        rst = 1'b1;
        #1;
        check("midrst_signature", signature, 16'h0000);
        check("midrst_busy", busy, 1'b0);
        check("midrst_dut_rst_n", dut_rst_n, 1'b0);
        check("midrst_dut_in", dut_in, 8'h00);
        step();
        rst = 1'b0;
        step();
        launch();
        wait_done(-1, cyc);
        check("postrst_done_cycle", cyc, 261);
        check("postrst_signature", signature, model);

        // Single-vector instance, two golden values
`ifdef BIST_COMPARE_EN
        exp_pass = 1'b1;
`else
        exp_pass = 1'b0;
`endif
        for (int run = 0; run < 2; run++) begin
            golden1 = (run == 0) ? 16'h0001 : 16'h0002;
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            cyc = 0;
            while (!done1 && cyc < 50) begin
                step();
                cyc++;
            end
            check("one_done_cycle", cyc, 5);
            check("one_signature", signature1, 16'h0001);
            check("one_pass", pass1, (run == 0) ? exp_pass : 1'b0);
            check("one_busy", busy1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
